// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - two-master round-robin arbiter for the single-port ram
//
// Shares one 32 x 32-bit single-port ram between two req/ack masters.
// Each transaction takes four cycles: IDLE (grant), ISSUE (ram access),
// WAIT (re-read of the same location), and ACK (one-cycle ack pulse).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mN_req, mN_wr, mN_addr,        master N request (held until ack), type,
//   mN_wdata                       address and write data (stable while req)
//   mN_ack, mN_rdata               one-cycle completion pulse, last read data
//   ram_cen, ram_wen, ram_addr,    registered ram control/address/data pins
//   ram_din                        (all zero whenever ram_cen is low)
//   ram_dout                       ram read data, registered inside the ram

module ram_bus_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_cen,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t            state, state_d;
   logic              owner, owner_d;
   logic              last_owner, last_owner_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              ram_cen_d, ram_wen_d;
   logic [ADDR_W-1:0] ram_addr_d;
   logic [DATA_W-1:0] ram_din_d;
   logic              m0_ack_d, m1_ack_d;
   logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;
   logic              grant1;

   always_comb begin
      state_d      = state;
      owner_d      = owner;
      last_owner_d = last_owner;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ram_cen_d    = 1'b0;
      ram_wen_d    = 1'b0;
      ram_addr_d   = '0;
      ram_din_d    = '0;
      m0_ack_d     = 1'b0;
      m1_ack_d     = 1'b0;
      m0_rdata_d   = m0_rdata;
      m1_rdata_d   = m1_rdata;
      grant1       = 1'b0;

      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               // Master 1 wins when alone, or on a tie when master 0 went last.
               grant1     = m1_req && (!m0_req || !last_owner);
               owner_d    = grant1;
               wr_d       = grant1 ? m1_wr    : m0_wr;
               addr_d     = grant1 ? m1_addr  : m0_addr;
               wdata_d    = grant1 ? m1_wdata : m0_wdata;
               ram_cen_d  = 1'b1;
               ram_wen_d  = wr_d;
               ram_addr_d = addr_d;
               ram_din_d  = wdata_d;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            // Read back the same location so ram_dout is steady at capture.
            ram_cen_d  = 1'b1;
            ram_addr_d = addr_q;
            state_d    = WAIT;
         end
         WAIT: begin
            if (!wr_q) begin
               if (owner) m1_rdata_d = ram_dout;
               else       m0_rdata_d = ram_dout;
            end
            m0_ack_d     = !owner;
            m1_ack_d     = owner;
            last_owner_d = owner;
            state_d      = ACK;
         end
         ACK: begin
            // Requests are not looked at here: the acked master is still
            // dropping its req and must not be granted again.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ram_cen    <= 1'b0;
         ram_wen    <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         state      <= state_d;
         owner      <= owner_d;
         last_owner <= last_owner_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ram_cen    <= ram_cen_d;
         ram_wen    <= ram_wen_d;
         ram_addr   <= ram_addr_d;
         ram_din    <= ram_din_d;
         m0_ack     <= m0_ack_d;
         m1_ack     <= m1_ack_d;
         m0_rdata   <= m0_rdata_d;
         m1_rdata   <= m1_rdata_d;
      end
   end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb/tb_ram_bus_arbiter.sv - scoreboard bench for ram_bus_arbiter with a behavioural ram

module tb_ram_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_wr, m0_ack;
   logic [4:0]  m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic        m1_req, m1_wr, m1_ack;
   logic [4:0]  m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic        ram_cen, ram_wen;
   logic [4:0]  ram_addr;
   logic [31:0] ram_din, ram_dout;

   ram_bus_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port ram: read-first, dout registered on access.
   logic [31:0] ram_mem  [32];
   logic [31:0] init_val [32];
   logic        mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) ram_mem[i] <= init_val[i];
      end else if (ram_cen) begin
         ram_dout <= ram_mem[ram_addr];
         if (ram_wen) ram_mem[ram_addr] <= ram_din;
      end
   end

   // Reference model: memory contents and each master's last read value.
   logic [31:0] ref_mem [32];
   logic [31:0] last_rd [2];

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
   } exp_t;
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t e;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      chk("ack_exclusive", {63'd0, m0_ack & m1_ack}, 64'd0);
      if (!ram_cen) chk("bus_zero_when_idle", {26'd0, ram_wen, ram_addr, ram_din}, 64'd0);
      if (m0_ack) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL m0_unexpected_ack: ack seen with no pending transaction (cycle %0d)", cyc);
         end else begin
            e = q0.pop_front();
            chk("m0_rdata", m0_rdata, e.rdata);
            if (e.cyc >= 0) chk("m0_ack_cycle", cyc, e.cyc);
         end
      end
      if (m1_ack) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL m1_unexpected_ack: ack seen with no pending transaction (cycle %0d)", cyc);
         end else begin
            e = q1.pop_front();
            chk("m1_rdata", m1_rdata, e.rdata);
            if (e.cyc >= 0) chk("m1_ack_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic start(input int m, input bit wr, input logic [4:0] a,
                        input logic [31:0] d, input int ecyc, input bit push);
      exp_t x;
      x.cyc   = ecyc;
      x.rdata = wr ? last_rd[m] : ref_mem[a];
      if (wr) ref_mem[a] = d;
      else    last_rd[m] = ref_mem[a];
      if (m == 0) begin
         m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d;
         if (push) q0.push_back(x);
      end else begin
         m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d;
         if (push) q1.push_back(x);
      end
   endtask

   task automatic wait_ack(input int m);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 24 && !got; i++) begin
         @(negedge clk);
         if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL m%0d_ack_timeout: no ack within 24 cycles, required one", m);
      end
      @(posedge clk);
      #1;
      if (m == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst    = 1'b1;
      m0_req = 1'b0;
      m1_req = 1'b0;
      q0.delete();
      q1.delete();
      last_rd[0] = '0;
      last_rd[1] = '0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ram_cen"},  {63'd0, ram_cen},  64'd0);
      chk({tag, "_ram_wen"},  {63'd0, ram_wen},  64'd0);
      chk({tag, "_ram_addr"}, {59'd0, ram_addr}, 64'd0);
      chk({tag, "_ram_din"},  {32'd0, ram_din},  64'd0);
      chk({tag, "_m0_ack"},   {63'd0, m0_ack},   64'd0);
      chk({tag, "_m1_ack"},   {63'd0, m1_ack},   64'd0);
      chk({tag, "_m0_rdata"}, {32'd0, m0_rdata}, 64'd0);
      chk({tag, "_m1_rdata"}, {32'd0, m1_rdata}, 64'd0);
   endtask

   task automatic random_master(input int m, input int count);
      int gap;
      for (int i = 0; i < count; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         start(m, 1'($urandom_range(0, 1)), {m[0], 4'($urandom_range(0, 15))},
               $urandom, -1, 1'b1);
         wait_ack(m);
      end
   endtask

   task automatic contend(input int m, input int n0);
      for (int i = 0; i < 3; i++) begin
         start(m, 1'($urandom_range(0, 1)), {m[0], 4'($urandom_range(0, 15))},
               $urandom, n0 + 3 + 4 * m + 8 * i, 1'b1);
         wait_ack(m);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
      for (int i = 0; i < 32; i++) begin
         init_val[i] = $urandom;
         ref_mem[i]  = init_val[i];
      end
      mem_init = 1'b1;
      do_reset(3);
      mem_init = 1'b0;
      check_all_zero("reset");

      // Write then read, single master, with exact bus timing.
      n = cyc;
      start(0, 1'b1, 5'd5, 32'hDEADBEEF, n + 3, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("issue_cen",  {63'd0, ram_cen},  64'd1);
      chk("issue_wen",  {63'd0, ram_wen},  64'd1);
      chk("issue_addr", {59'd0, ram_addr}, 64'd5);
      chk("issue_din",  {32'd0, ram_din},  64'hDEADBEEF);
      @(negedge clk);
      chk("wait_cen",  {63'd0, ram_cen},  64'd1);
      chk("wait_wen",  {63'd0, ram_wen},  64'd0);
      chk("wait_addr", {59'd0, ram_addr}, 64'd5);
      wait_ack(0);
      start(0, 1'b0, 5'd5, 32'h0, cyc + 3, 1'b1);
      wait_ack(0);

      // First tie after reset goes to master 0.
      do_reset(1);
      n = cyc;
      start(0, 1'b0, 5'd1, 32'h0,    n + 3, 1'b1);
      start(1, 1'b1, 5'd2, 32'h1234, n + 7, 1'b1);
      fork
         wait_ack(0);
         wait_ack(1);
      join
      chk("m0_rdata_hold", m0_rdata, last_rd[0]);

      // Sustained contention: alternating grants, 4 cycles apart.
      n = cyc;
      fork
         contend(0, n);
         contend(1, n);
      join

      // Write leaves rdata untouched.
      start(1, 1'b0, 5'd2, 32'h0, cyc + 3, 1'b1);
      wait_ack(1);
      start(1, 1'b1, 5'd2, 32'h5, cyc + 3, 1'b1);
      wait_ack(1);
      start(1, 1'b0, 5'd2, 32'h0, cyc + 3, 1'b1);
      wait_ack(1);

      // Reset during WAIT of a write: abandoned but committed.
      start(0, 1'b1, 5'd9, 32'hA5, -1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("rst_wait");
      m0_req = 1'b0;
      rst = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      start(0, 1'b0, 5'd9, 32'h0, cyc + 3, 1'b1);
      wait_ack(0);

      // Reset in IDLE with master 1 pending.
      rst = 1'b1;
      q0.delete();
      q1.delete();
      last_rd[0] = '0;
      last_rd[1] = '0;
      start(1, 1'b0, 5'd20, 32'h0, cyc + 4, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_ack(1);

      // Randomized traffic on disjoint address halves.
      fork
         random_master(0, 15);
         random_master(1, 15);
      join

      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations: %0d/%0d pending, required 0/0", q0.size(), q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Two-master bus arbiter that shares the 32 x 32-bit single-port `ram` between two requesters. It sits between the masters and `ram` and is the only driver of `ram`'s `cen`, `wen`, `addr` and `din` pins. Each master gets a req/ack handshake for one read or write at a time. Contention is resolved by round-robin, and read data is returned in a per-master holding register.

## Interface
Parameters:
- `ADDR_W`, 5, RAM address width (32 locations).
- `DATA_W`, 32, RAM data width.

Ports:
- `clk`  in  1  rising-edge clock, shared with `ram`.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req`  in  1  master 0 request; held high until `m0_ack`.
- `m0_wr`  in  1  master 0 access type: 1 = write, 0 = read; stable while `m0_req`.
- `m0_addr`  in  ADDR_W  master 0 address; stable while `m0_req`.
- `m0_wdata`  in  DATA_W  master 0 write data; stable while `m0_req`.
- `m0_ack`  out  1  one-cycle completion pulse to master 0.
- `m0_rdata`  out  DATA_W  master 0 last read data; valid when `m0_ack` is high after a read.
- `m1_req`, `m1_wr`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: identical to the master 0 ports, for master 1.
- `ram_cen`  out  1  to `ram` `cen`.
- `ram_wen`  out  1  to `ram` `wen`.
- `ram_addr`  out  ADDR_W  to `ram` `addr`.
- `ram_din`  out  DATA_W  to `ram` `din`.
- `ram_dout`  in  DATA_W  from `ram` `dout`; registered by `ram` on the edge that samples `cen`/`wen`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- **IDLE**
  - No req: stay in IDLE.
  - A single req: that master becomes owner.
  - Both req: owner is the master that is not `last_owner`.
  - On a grant: latch owner, wr, addr and wdata; load the RAM output registers; go to ISSUE.
- **ISSUE**
  - `ram_cen=1`, `ram_wen=wr`, `ram_addr`/`ram_din` set from the latched values.
  - `ram` writes or reads on the edge ending ISSUE. Go to WAIT.
- **WAIT**
  - `ram_cen=1`, `ram_wen=0`, same `ram_addr`. This re-reads the same location so `ram_dout` is stable across the capture edge, which avoids a sample race. After a write, this returns the newly written data.
  - On the edge ending WAIT: if the transaction is a read, capture `ram_dout` into the owner's `rdata`. Set `last_owner` to the owner and go to ACK.
- **ACK**
  - `ram_cen=0`. The owner's ack is high for exactly this cycle.
  - Requests are ignored in this cycle, so the master's dropping req is never re-granted. Go to IDLE.
- `ram_wen`, `ram_addr` and `ram_din` are 0 whenever `ram_cen=0`.
- A write never modifies the master's `rdata`; it holds its previous value.
- The non-owner's req is held pending. Its fields must stay stable and are sampled only when it is granted.
- A master dropping req before its ack is a protocol violation; behaviour is undefined and need not be checked.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge):
  - state = IDLE, `last_owner` = 1 (master 0 wins the first tie).
  - `ram_cen`, `ram_wen`, `ram_addr`, `ram_din`, `m0_ack`, `m1_ack` = 0; `m0_rdata`, `m1_rdata` = 0.
- Latency: req high in IDLE cycle N -> `ram_cen` high in N+1 -> ack high in N+3.
- Throughput: one transaction per 4 cycles. For back-to-back requests from the same master, req is re-sampled in the IDLE cycle after ack.
- Fairness: while both masters request continuously, grants alternate m0, m1, m0, …; the loser waits exactly 4 cycles.
- Reset mid-transaction:
  - The transaction is abandoned: no ack, `rdata` cleared.
  - If reset lands after the ISSUE edge, a write has already been committed to `ram`; before that edge, nothing has been written.
  - Requests still high after reset is released are arbitrated in the first IDLE cycle.
- Request arrival: a req that rises in any non-IDLE cycle is first seen in the next IDLE cycle.

## Test plan
- **Write then read, single master:** m0 writes 0xDEADBEEF to addr 5 -> `ram_cen`=1/`ram_wen`=1/`ram_addr`=5 in cycle N+1, `m0_ack` in N+3. Then m0 reads addr 5 -> `m0_rdata`=0xDEADBEEF while `m0_ack`=1.
- **First tie after reset:** m0 and m1 both req in the same cycle (m0 reads addr 1, m1 writes 0x1234 to addr 2) -> m0 granted first (ack at N+3), m1 ack at N+7; `m0_rdata` stays unchanged by m1's write.
- **Sustained contention:** both masters request continuously for 6 transactions -> acks alternate m0, m1, m0, m1, m0, m1, each 4 cycles apart; no ack ever coincides with the other master's ack.
- **Write-only activity:** m1 reads addr 2 -> 0x1234. Then m1 writes 0x5 to addr 2 -> `m1_rdata` holds 0x1234 during the write ack. A following read returns 0x5.
- **Reset in WAIT:** assert `rst` during the WAIT state of an m0 write of 0xA5 to addr 9 -> no `m0_ack`, all outputs 0 the next cycle. A later read of addr 9 returns 0xA5.
- **Reset in IDLE with m1 pending:** assert `rst` while m1's req is high -> after release, m1 is granted in the first IDLE cycle and acked 3 cycles later.
